// File: rtl/approx_fp16_sqr_pipe_if.sv
// Valid/ready handshake bundle for the FP16 squaring stage.
// The master drives operands and result-side backpressure; the slave is the squarer.
interface approx_fp16_sqr_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/approx_fp16_sqr_pipe.sv
// Two-stage FP16 squarer: segmented-LUT approximation or exact round-to-nearest-even,
// with IEEE special handling and a saturating overflow event counter.
module approx_fp16_sqr_pipe #(
    parameter int SEG_BITS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    approx_fp16_sqr_pipe_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     ovf_cnt
);

    localparam int SEGS = 1 << SEG_BITS;

    // Entry = {carry, frac}: square of the segment midpoint, normalised to [1,2)
    // and rounded half-up to 10 fraction bits.
    function automatic logic [10:0] lut_entry(input int k);
        logic [63:0] n;
        logic [63:0] sq;
        logic [63:0] r;
        n  = 64'((1 << (SEG_BITS + 1)) + 2 * k + 1);
        sq = n * n;
        if (sq >= (64'd1 << (2 * SEG_BITS + 3))) begin
            r = ((sq << 10) + (64'd1 << (2 * SEG_BITS + 2))) >> (2 * SEG_BITS + 3);
            lut_entry = {1'b1, 10'(r - 64'd1024)};
        end else begin
            r = ((sq << 10) + (64'd1 << (2 * SEG_BITS + 1))) >> (2 * SEG_BITS + 2);
            lut_entry = 11'(r - 64'd1024);
        end
    endfunction

    logic [10:0] lut [SEGS];

    for (genvar g = 0; g < SEGS; g++) begin : g_lut
        localparam logic [10:0] ENTRY = lut_entry(g);
        assign lut[g] = ENTRY;
    end

    logic        s1_valid;
    logic        s1_mode;
    logic [15:0] s1_data;
    logic        s2_valid;
    logic        s2_ovf;
    logic [15:0] s2_data;
    logic        adv;

    assign adv          = !s2_valid || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;

    logic [4:0]  e;
    logic [9:0]  f;
    logic [10:0] m;
    logic [21:0] p;
    logic [9:0]  mant_t;
    logic        guard;
    logic        sticky;
    logic        rnd;
    logic [10:0] mant_r;
    logic [10:0] lut_val;
    logic        sign_unused;

    // Squares are never negative, so the operand sign is simply discarded.
    assign sign_unused = s1_data[15];
    assign e       = s1_data[14:10];
    assign f       = s1_data[9:0];
    assign m       = {1'b1, f};
    assign p       = 22'(m) * 22'(m);
    assign mant_t  = p[21] ? p[20:11] : p[19:10];
    assign guard   = p[21] ? p[10] : p[9];
    assign sticky  = p[21] ? |p[9:0] : |p[8:0];
    assign rnd     = guard & (sticky | mant_t[0]);
    assign mant_r  = {1'b0, mant_t} + {10'b0, rnd};
    assign lut_val = lut[f[9 -: SEG_BITS]];

    logic [9:0]        mant;
    logic [1:0]        inc;
    logic signed [7:0] exp_s;
    logic [15:0]       res_data;
    logic              res_ovf;

    always_comb begin
        mant     = lut_val[9:0];
        inc      = {1'b0, lut_val[10]};
        res_data = 16'h0000;
        res_ovf  = 1'b0;
        if (s1_mode) begin
            mant = mant_r[9:0];
            inc  = {1'b0, p[21]} + {1'b0, mant_r[10]};
        end
        exp_s = $signed({2'b00, e, 1'b0}) - 8'sd15 + $signed({6'b0, inc});
        if (e == 5'd31) begin
            res_data = (f != 10'd0) ? 16'h7E00 : 16'h7C00;
        end else if (e == 5'd0) begin
            res_data = 16'h0000;
        end else if (exp_s >= 8'sd31) begin
            res_data = 16'h7C00;
            res_ovf  = 1'b1;
        end else if (exp_s <= 8'sd0) begin
            res_data = 16'h0000;
        end else begin
            res_data = {1'b0, exp_s[4:0], mant};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= 16'h0000;
            s2_valid <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_data  <= 16'h0000;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_mode  <= bus.in_mode;
            s1_data  <= bus.in_data;
            s2_valid <= s1_valid;
            s2_ovf   <= res_ovf;
            s2_data  <= res_data;
        end
    end

    // Only overflow results actually handed downstream are counted; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (cnt_clr) begin
            ovf_cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_ovf && (ovf_cnt != {CNT_W{1'b1}})) begin
            ovf_cnt <= ovf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
